// File: rtl/mc_reconstruct.sv
// Decoder motion-compensated reconstruction: clip(ref_block + residual),
// streamed one row per valid/ready handshake, followed by a done pulse.
module mc_reconstruct #(
    parameter int MB_SIZE        = 4,
    parameter int PIXEL_WIDTH    = 8,
    parameter int REF_FRAME_SIZE = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [5:0]                             mv_x,
    input  logic [5:0]                             mv_y,
    input  logic [0:REF_FRAME_SIZE-1][0:REF_FRAME_SIZE-1][PIXEL_WIDTH-1:0] ref_frame,
    input  logic [0:MB_SIZE-1][0:MB_SIZE-1][PIXEL_WIDTH:0] residual,
    output logic                                   busy,
    output logic                                   row_valid,
    input  logic                                   row_ready,
    output logic [$clog2(MB_SIZE)-1:0]             row_idx,
    output logic [0:MB_SIZE-1][PIXEL_WIDTH-1:0]    recon_row,
    output logic                                   done
);

    localparam int RW = $clog2(MB_SIZE);
    localparam int CW = $clog2(REF_FRAME_SIZE);
    localparam int SW = PIXEL_WIDTH + 2;
    localparam logic signed [SW-1:0] LIM = SW'((1 << PIXEL_WIDTH) - 1);

    typedef logic [0:MB_SIZE-1][PIXEL_WIDTH-1:0] row_t;
    typedef logic [0:MB_SIZE-1][PIXEL_WIDTH:0] res_row_t;
    typedef logic [0:MB_SIZE-1][0:MB_SIZE-1][PIXEL_WIDTH:0] res_blk_t;
    typedef logic [0:REF_FRAME_SIZE-1][0:REF_FRAME_SIZE-1][PIXEL_WIDTH-1:0] frame_t;
    typedef enum logic [1:0] {IDLE, OUT, DONE} state_t;

    state_t          state_q, state_d;
    logic [5:0]      mvx_q, mvx_d, mvy_q, mvy_d;
    res_blk_t        res_q, res_d;
    logic            valid_d, done_d;
    logic [RW-1:0]   idx_d, sel_r;
    row_t            row_d, cand;
    logic [5:0]      sel_mx, sel_my;
    res_row_t        sel_res;

    // Edge replication: coordinates past the frame edge read the last pixel
    function automatic logic [CW-1:0] clamp(input logic [6:0] v);
        if (v > 7'(REF_FRAME_SIZE - 1)) return CW'(REF_FRAME_SIZE - 1);
        return v[CW-1:0];
    endfunction

    function automatic row_t calc_row(
        input logic [RW-1:0] r,
        input logic [5:0]    mx,
        input logic [5:0]    my,
        input res_row_t      rr,
        input frame_t        rf
    );
        row_t                  o;
        logic [CW-1:0]         y;
        logic [CW-1:0]         x;
        logic signed [SW-1:0]  s;
        o = '0;
        y = clamp(7'(r) + 7'(my));
        for (int c = 0; c < MB_SIZE; c++) begin
            x = clamp(7'(c) + 7'(mx));
            s = $signed({2'b00, rf[y][x]}) + $signed({rr[c][PIXEL_WIDTH], rr[c]});
            if (s < 0)        o[c] = '0;
            else if (s > LIM) o[c] = '1;
            else              o[c] = s[PIXEL_WIDTH-1:0];
        end
        return o;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mvx_q     <= '0;
            mvy_q     <= '0;
            res_q     <= '0;
            row_valid <= 1'b0;
            row_idx   <= '0;
            recon_row <= '0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mvx_q     <= mvx_d;
            mvy_q     <= mvy_d;
            res_q     <= res_d;
            row_valid <= valid_d;
            row_idx   <= idx_d;
            recon_row <= row_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mvx_d   = mvx_q;
        mvy_d   = mvy_q;
        res_d   = res_q;
        valid_d = row_valid;
        idx_d   = row_idx;
        row_d   = recon_row;
        done_d  = 1'b0;
        // Row 0 comes straight from the start inputs; later rows from the captured copy
        if (state_q == IDLE) begin
            sel_r   = '0;
            sel_mx  = mv_x;
            sel_my  = mv_y;
            sel_res = residual[0];
        end else begin
            sel_r   = row_idx + 1'b1;
            sel_mx  = mvx_q;
            sel_my  = mvy_q;
            sel_res = res_q[sel_r];
        end
        cand = calc_row(sel_r, sel_mx, sel_my, sel_res, ref_frame);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = OUT;
                    mvx_d   = mv_x;
                    mvy_d   = mv_y;
                    res_d   = residual;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    row_d   = cand;
                end
            end
            OUT: begin
                if (row_ready) begin
                    if (row_idx == RW'(MB_SIZE - 1)) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d = sel_r;
                        row_d = cand;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule
